mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//  Iterative multiply/divide engine downstream of the register file: consumes rd_data1/rd_data2
//  (rs/rt) and produces 64-bit results in architectural HI/LO registers for mfhi/mflo.
//  The multi-cycle controller starts it and holds the instruction state while busy is high.
//  Radix-2, one bit per cycle: shift-add multiply, restoring divide.
// PARAMETERS
//  WIDTH   32  operand width; HI and LO are each WIDTH bits
//  CNT_W   5   iteration counter width, = $clog2(WIDTH)
// PORTS
//  clk          in   1      system clock, all state changes on posedge
//  rst          in   1      synchronous, active-high reset
//  start        in   1      launch operation; sampled only in IDLE or DONE
//  op           in   2      00 multu, 01 mult, 10 divu, 11 div
//  src_a        in   WIDTH  multiplicand / dividend (rd_data1)
//  src_b        in   WIDTH  multiplier / divisor (rd_data2)
//  wr_hi        in   1      mthi: HI <= wr_data
//  wr_lo        in   1      mtlo: LO <= wr_data
//  wr_data      in   WIDTH  data for mthi/mtlo
//  busy         out  1      high while state == RUN
//  done         out  1      one-cycle pulse, state == DONE
//  div_by_zero  out  1      valid with done; high when the finished div/divu had src_b == 0
//  hi           out  WIDTH  HI register (mul: upper product; div: remainder)
//  lo           out  WIDTH  LO register (mul: lower product; div: quotient)
// BEHAVIOUR
//  Clock is clk; reset is rst, synchronous and active-high: IDLE, hi=lo=0, busy=done=div_by_zero=0, count=0.
//  FSM IDLE -> RUN (start) -> DONE (count == WIDTH-1 iteration done) -> IDLE, or DONE -> RUN on start.
//  Edge E0 with start: latch op and operand magnitudes; count=0; state RUN.
//  E1..E32: one iteration per edge. At E32, hi/lo are written and state goes DONE.
//   Latency is fixed at 33 edges from start to done, including divide-by-zero.
//  start during RUN: ignored; operands are not re-latched.
//  Multiply: 2*WIDTH-bit accumulator; {hi,lo} = a*b.
//  Divide: restoring; lo = a/b (truncate toward zero), hi = a%b (remainder sign follows dividend).
//  Divide by zero: no trap; lo = all-ones, hi = src_a as latched, div_by_zero = 1 for the done cycle.
//  wr_hi/wr_lo: take effect at the next edge in IDLE or DONE. In RUN they are ignored.
//   wr_hi/wr_lo coincident with start: the write applies, and the result later overwrites it.
//  rst mid-RUN: operation abandoned, reset values restored, no done pulse.
// CONFIGURATION
//  MULT_DIV_SIGNED_EN defined: op[0]=1 selects signed mult/div.
//   Operands are converted to magnitudes at E0; the result sign is fixed at E32.
//   Product sign = a^b. Quotient sign = a^b. Remainder sign = a.
//   div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
//  Undefined: op[0] is ignored; mult behaves as multu and div as divu.
// STRUCTURE
//  Package mult_div_pkg contains:
//   op encodings OP_MULTU/OP_MULT/OP_DIVU/OP_DIV
//   state typedef md_state_t {IDLE, RUN, DONE}
//   localparam ITER = WIDTH
//  Sub-module md_sign_fix (combinational): conditional two's-complement negate.
//   Used for operand magnitude at entry and for result sign correction at exit.
//  The top level holds the FSM, counter, accumulator/remainder shift registers and HI/LO.
// TESTING
//  multu 0xFFFFFFFF*0xFFFFFFFF -> done at edge 33; hi=0xFFFFFFFE, lo=0x00000001; busy high for 32 cycles.
//  divu 100/7 -> lo=14, hi=2, div_by_zero=0; then divu 5/0 -> lo=0xFFFFFFFF, hi=5, div_by_zero=1.
//  Signed (SIGNED_EN): mult -3*5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. div -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//  Without SIGNED_EN: mult 0xFFFFFFFF*2 -> hi=1, lo=0xFFFFFFFE.
//  Protocol:
//   start pulsed mid-RUN -> ignored, result unchanged.
//   start in DONE cycle -> back-to-back op, second done 33 edges later.
//   wr_lo=0x1234 in IDLE -> lo=0x1234; wr_lo in RUN -> ignored.
//  rst asserted at iteration 10 -> next cycle busy=0, hi=lo=0, no done; a new op completes correctly.

Source files
------------

// File: rtl/mult_div_pkg.sv
// -----------------------------------------------------------------------------
// mult_div_pkg
//  Shared definitions for the iterative multiply/divide unit:
//   - default operand width and iteration-counter width
//   - op encodings (multu / mult / divu / div)
//   - controller state type
//  Build option: MULT_DIV_SIGNED_EN (see mult_div_unit) changes how op[0] is
//  interpreted, not anything declared here.
// -----------------------------------------------------------------------------
package mult_div_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = 5;    // $clog2(WIDTH)
  localparam int ITER  = WIDTH; // one result bit per iteration

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } md_state_t;

endpackage

// File: rtl/md_sign_fix.sv
// -----------------------------------------------------------------------------
// md_sign_fix
//  Combinational conditional two's-complement negate.
//  Used on the way in (operand -> magnitude) and on the way out
//  (unsigned result -> signed result).
//  Ports:
//   neg   in   1   1: dout = -din, 0: dout = din
//   din   in   W   value to condition
//   dout  out  W   conditioned value
// -----------------------------------------------------------------------------
module md_sign_fix
  import mult_div_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  assign dout = neg ? (~din + W'(1)) : din;

endmodule

// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
//  Radix-2 iterative multiply/divide engine feeding the architectural HI/LO
//  registers. Shift-add multiply and restoring divide, one bit per clock.
//  Fixed latency: start is sampled on edge E0, 32 iterations run on E1..E32,
//  and the result lands in HI/LO on E32 together with the done pulse.
//
//  Build option MULT_DIV_SIGNED_EN:
//   defined   - op[0]=1 selects signed mult/div (operands converted to
//               magnitudes at E0, result sign restored at E32)
//   undefined - op[0] ignored; mult behaves as multu, div as divu
//
//  Ports:
//   clk          in   1      clock, all state changes on posedge
//   rst          in   1      synchronous active-high reset
//   start        in   1      launch; sampled only in IDLE or DONE
//   op           in   2      00 multu, 01 mult, 10 divu, 11 div
//   src_a        in   WIDTH  multiplicand / dividend
//   src_b        in   WIDTH  multiplier / divisor
//   wr_hi        in   1      mthi: HI <= wr_data (IDLE/DONE only)
//   wr_lo        in   1      mtlo: LO <= wr_data (IDLE/DONE only)
//   wr_data      in   WIDTH  data for mthi/mtlo
//   busy         out  1      high while running
//   done         out  1      one-cycle completion pulse
//   div_by_zero  out  1      with done: finished divide had src_b == 0
//   hi           out  WIDTH  HI (upper product / remainder)
//   lo           out  WIDTH  LO (lower product / quotient)
// -----------------------------------------------------------------------------
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  import mult_div_pkg::*;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  md_state_t        state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Working registers. For multiply acc_hi:acc_lo is the product/multiplier
  // shift register and addend holds the multiplicand. For divide acc_hi is
  // the partial remainder, acc_lo shifts the dividend out and the quotient
  // in, and addend holds the divisor.
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] addend_q, addend_d;
  logic             is_div_q, is_div_d;
  logic             res_neg_q, res_neg_d;  // product / quotient sign
  logic             rem_neg_q, rem_neg_d;  // remainder sign (dividend sign)
  logic             b_zero_q, b_zero_d;

  // ---------------------------------------------------------------------------
  // Operand decode and magnitude conversion (used only on the launch edge)
  // ---------------------------------------------------------------------------
  logic             op_is_div;
  logic             op_signed;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign op_is_div = (op == OP_DIVU) || (op == OP_DIV);
`ifdef MULT_DIV_SIGNED_EN
  assign op_signed = (op == OP_MULT) || (op == OP_DIV);
`else
  assign op_signed = 1'b0;
`endif
  assign a_neg = op_signed & src_a[WIDTH-1];
  assign b_neg = op_signed & src_b[WIDTH-1];

  md_sign_fix #(.W(WIDTH)) u_mag_a (.neg(a_neg), .din(src_a), .dout(mag_a));
  md_sign_fix #(.W(WIDTH)) u_mag_b (.neg(b_neg), .din(src_b), .dout(mag_b));

  // ---------------------------------------------------------------------------
  // One iteration of each algorithm
  // ---------------------------------------------------------------------------
  // Shift-add: add the multiplicand into the upper half when the current
  // multiplier bit is set, then shift the whole 2W+1-bit value right.
  logic [WIDTH-1:0] mul_addend;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_n, mul_lo_n;

  assign mul_addend = acc_lo_q[0] ? addend_q : '0;
  assign mul_sum    = {1'b0, acc_hi_q} + {1'b0, mul_addend};
  assign mul_hi_n   = mul_sum[WIDTH:1];
  assign mul_lo_n   = {mul_sum[0], acc_lo_q[WIDTH-1:1]};

  // Restoring divide: shift the next dividend bit into the remainder and
  // subtract the divisor if it fits. The remainder is always below the
  // divisor, so the shifted value needs one extra bit, and the W-bit
  // difference is exact whenever the subtraction is kept.
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] div_hi_n, div_lo_n;

  assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, addend_q};
  assign div_diff  = div_shift[WIDTH-1:0] - addend_q;
  assign div_hi_n  = div_ge ? div_diff : div_shift[WIDTH-1:0];
  assign div_lo_n  = {acc_lo_q[WIDTH-2:0], div_ge};

  logic [WIDTH-1:0] step_hi, step_lo;
  assign step_hi = is_div_q ? div_hi_n : mul_hi_n;
  assign step_lo = is_div_q ? div_lo_n : mul_lo_n;

  // ---------------------------------------------------------------------------
  // Result sign restoration (only meaningful on the final iteration)
  // ---------------------------------------------------------------------------
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  md_sign_fix #(.W(2*WIDTH)) u_fix_prod (
    .neg  (res_neg_q & ~is_div_q),
    .din  ({step_hi, step_lo}),
    .dout (prod_fix)
  );
  md_sign_fix #(.W(WIDTH)) u_fix_quot (
    .neg  (res_neg_q & is_div_q),
    .din  (step_lo),
    .dout (quot_fix)
  );
  // With a zero divisor the remainder path carries the dividend magnitude,
  // so restoring the dividend sign returns the operand exactly as latched.
  md_sign_fix #(.W(WIDTH)) u_fix_rem (
    .neg  (rem_neg_q & is_div_q),
    .din  (step_hi),
    .dout (rem_fix)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    dbz_d     = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;
    count_d   = count_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    addend_d  = addend_q;
    is_div_d  = is_div_q;
    res_neg_d = res_neg_q;
    rem_neg_d = rem_neg_q;
    b_zero_d  = b_zero_q;

    case (state_q)
      IDLE, DONE: begin
        // mthi/mtlo land even on the launch edge; the result overwrites
        // them later.
        if (wr_hi) hi_d = wr_data;
        if (wr_lo) lo_d = wr_data;
        if (start) begin
          state_d   = RUN;
          count_d   = '0;
          is_div_d  = op_is_div;
          res_neg_d = a_neg ^ b_neg;
          rem_neg_d = a_neg;
          b_zero_d  = (src_b == '0);
          acc_hi_d  = '0;
          acc_lo_d  = op_is_div ? mag_a : mag_b;
          addend_d  = op_is_div ? mag_b : mag_a;
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        acc_hi_d = step_hi;
        acc_lo_d = step_lo;
        if (count_q == LAST) begin
          state_d = DONE;
          done_d  = 1'b1;
          if (is_div_q) begin
            dbz_d = b_zero_q;
            hi_d  = rem_fix;
            lo_d  = b_zero_q ? '1 : quot_fix;
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      count_q   <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      addend_q  <= '0;
      is_div_q  <= 1'b0;
      res_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      b_zero_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      count_q   <= count_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      addend_q  <= addend_d;
      is_div_q  <= is_div_d;
      res_neg_q <= res_neg_d;
      rem_neg_q <= rem_neg_d;
      b_zero_q  <= b_zero_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mult_div_unit
//  Directed bench for mult_div_unit. Expected HI/LO/div_by_zero values are
//  queued when an operation is launched and popped when done is seen.
//  Signed cases are exercised when MULT_DIV_SIGNED_EN is defined; otherwise
//  the same op codes are checked for unsigned behaviour.
// -----------------------------------------------------------------------------
module tb_mult_div_unit;
  import mult_div_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic         wr_hi = 1'b0;
  logic         wr_lo = 1'b0;
  logic [W-1:0] wr_data = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  mult_div_unit dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .src_a       (src_a),
    .src_b       (src_b),
    .wr_hi       (wr_hi),
    .wr_lo       (wr_lo),
    .wr_data     (wr_data),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } exp_t;

  exp_t         exp_q[$];
  int           errors = 0;
  int           checks = 0;
  int           start_cyc = 0;
  int           busy_seen = 0;
  logic [W-1:0] last_lo = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic expect_res(input logic [W-1:0] h, input logic [W-1:0] l, input logic z);
    exp_t e;
    e.hi  = h;
    e.lo  = l;
    e.dbz = z;
    exp_q.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge just after launch edge E0.
  task automatic launch(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    op    = o;
    src_a = a;
    src_b = b;
    start = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    start_cyc = cyc;
  endtask

  // Waits (bounded) for done, checks latency and pops the scoreboard.
  task automatic wait_done(input string tag);
    int   n;
    exp_t e;
    n = 0;
    busy_seen = 0;
    while (done !== 1'b1 && n < 80) begin
      if (busy === 1'b1) busy_seen++;
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, 64'(done), 64'(1));
    chk({tag, "_latency"}, 64'(cyc - start_cyc + 1), 64'(ITER + 1));
    chk({tag, "_busy_low"}, 64'(busy), 64'(0));
    chk({tag, "_sb_avail"}, 64'(exp_q.size() != 0), 64'(1));
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, "_hi"}, 64'(hi), 64'(e.hi));
      chk({tag, "_lo"}, 64'(lo), 64'(e.lo));
      chk({tag, "_dbz"}, 64'(div_by_zero), 64'(e.dbz));
      last_lo = e.lo;
      $display("op %s: hi=%h lo=%h dbz=%0b", tag, hi, lo, div_by_zero);
    end
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [63:0]  prod;
    logic         any_done;

    // ---- reset ----
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_dbz", 64'(div_by_zero), 64'(0));
    chk("rst_hi", 64'(hi), 64'(0));
    chk("rst_lo", 64'(lo), 64'(0));

    // ---- mtlo / mthi in IDLE ----
    wr_lo = 1'b1; wr_data = 32'h0000_1234;
    @(negedge clk);
    wr_lo = 1'b0;
    chk("mtlo_idle", 64'(lo), 64'h1234);
    wr_hi = 1'b1; wr_data = 32'h0000_ABCD;
    @(negedge clk);
    wr_hi = 1'b0;
    chk("mthi_idle", 64'(hi), 64'hABCD);

    // ---- multu max * max ----
    expect_res(32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    launch(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu_max");
    chk("multu_max_busy_cycles", 64'(busy_seen), 64'(ITER));
    @(negedge clk);
    chk("done_pulse_width", 64'(done), 64'(0));

    // ---- divu 100 / 7 and divide by zero ----
    expect_res(32'd2, 32'd14, 1'b0);
    launch(OP_DIVU, 32'd100, 32'd7);
    wait_done("divu_100_7");
    @(negedge clk);
    expect_res(32'd5, 32'hFFFF_FFFF, 1'b1);
    launch(OP_DIVU, 32'd5, 32'd0);
    wait_done("divu_by_zero");
    @(negedge clk);
    chk("dbz_pulse_width", 64'(div_by_zero), 64'(0));

`ifdef MULT_DIV_SIGNED_EN
    expect_res(32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    launch(OP_MULT, 32'hFFFF_FFFD, 32'd5);
    wait_done("mult_m3_5");
    expect_res(32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);
    launch(OP_DIV, 32'hFFFF_FFF9, 32'd0);
    wait_done("div_m7_0");
    expect_res(32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    launch(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done("div_m7_2");
    expect_res(32'h0000_0000, 32'h8000_0000, 1'b0);
    launch(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_min_m1");
`else
    expect_res(32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
    launch(OP_MULT, 32'hFFFF_FFFF, 32'd2);
    wait_done("mult_as_multu");
    expect_res(32'h0000_0001, 32'h7FFF_FFFC, 1'b0);
    launch(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done("div_as_divu");
`endif
    @(negedge clk);

    // ---- start and mtlo during RUN are ignored ----
    prod = 64'(32'd1234) * 64'(32'd5678);
    expect_res(prod[63:32], prod[31:0], 1'b0);
    launch(OP_MULTU, 32'd1234, 32'd5678);
    repeat (4) @(negedge clk);
    start = 1'b1; op = OP_DIVU; src_a = 32'd9; src_b = 32'd3;
    wr_lo = 1'b1; wr_data = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0; wr_lo = 1'b0;
    chk("run_mtlo_ignored", 64'(lo), 64'(last_lo));
    chk("run_busy_held", 64'(busy), 64'(1));
    wait_done("midrun_start");

    // ---- back-to-back: start in the DONE cycle ----
    expect_res(32'd10, 32'd30, 1'b0);
    launch(OP_DIVU, 32'd1000, 32'd33);
    chk("b2b_busy", 64'(busy), 64'(1));
    wait_done("back_to_back");
    @(negedge clk);

    // ---- mthi coincident with start: write lands, result overwrites ----
    expect_res(32'd0, 32'd42, 1'b0);
    wr_hi = 1'b1; wr_data = 32'h0000_5555;
    launch(OP_MULTU, 32'd7, 32'd6);
    wr_hi = 1'b0;
    chk("mthi_with_start", 64'(hi), 64'h5555);
    wait_done("mthi_overwrite");
    @(negedge clk);

    // ---- reset mid-run ----
    launch(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_hi", 64'(hi), 64'(0));
    chk("midrst_lo", 64'(lo), 64'(0));
    any_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) any_done = 1'b1;
      @(negedge clk);
    end
    chk("midrst_no_done", 64'(any_done), 64'(0));

    expect_res(32'd1, 32'd0, 1'b0);
    launch(OP_MULTU, 32'h0001_0000, 32'h0001_0000);
    wait_done("after_reset");
    @(negedge clk);

    // ---- a few random unsigned operations ----
    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      if (i % 2 == 0) begin
        rb   = $urandom;
        prod = 64'(ra) * 64'(rb);
        expect_res(prod[63:32], prod[31:0], 1'b0);
        launch(OP_MULTU, ra, rb);
        wait_done("rand_multu");
      end else begin
        rb = $urandom_range(1, 100000);
        expect_res(ra % rb, ra / rb, 1'b0);
        launch(OP_DIVU, ra, rb);
        wait_done("rand_divu");
      end
      @(negedge clk);
    end

    chk("sb_drained", 64'(exp_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
